led_pwm_dimmer: RTL and testbench

- PWM generator stage directly downstream of the 4-bit duty-select multiplexer in the LED dimmer path.
- Takes the selected 4-bit brightness code and produces a glitch-free PWM drive for one LED.
- Brightness changes take effect only at PWM period boundaries.
- An optional soft ramp steps the applied level one code at a time toward the requested code.

---
 rtl/led_pwm_dimmer_pkg.sv | 20 ++
 rtl/pwm_prescaler.sv | 31 +++
 rtl/led_pwm_dimmer.sv | 90 +++++++++
 tb/tb_led_pwm_dimmer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/led_pwm_dimmer_pkg.sv
// Shared constants and helpers for the LED PWM dimmer and its prescaler.
// No logic of its own; no latency, no backpressure.
package led_pwm_dimmer_pkg;

  localparam int CODE_W    = 4;
  localparam int PWM_STEPS = 15;
  localparam int LEVEL_MAX = 15;
  localparam int PRESC_W   = 16;
  localparam int RAMP_W    = 8;

  typedef logic [CODE_W-1:0] level_t;

  // One code toward the target; the LEVEL_MAX guard keeps the step saturating.
  function automatic level_t step_toward(input level_t cur, input level_t tgt);
    if ((cur < tgt) && (cur < level_t'(LEVEL_MAX))) return cur + level_t'(1);
    else if (cur > tgt)                             return cur - level_t'(1);
    else                                            return cur;
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Free-running divider: one-cycle tick every PRESCALE enabled clocks.
// tick is combinational from the count register; en=0 clears the count (no backpressure).
module pwm_prescaler
  import led_pwm_dimmer_pkg::*;
#(
  parameter int PRESCALE = 100
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic tick
);

  localparam logic [PRESC_W-1:0] CNT_LAST = PRESC_W'(PRESCALE - 1);

  logic [PRESC_W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (!en || tick) cnt_d = '0;
    else             cnt_d = cnt_q + PRESC_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_pwm_dimmer.sv
// 15-step PWM LED drive from a 4-bit brightness code, level changes only at period boundaries.
// pwm_out/period_start registered (1 clock after counters); optional soft ramp; no backpressure.
module led_pwm_dimmer
  import led_pwm_dimmer_pkg::*;
#(
  parameter int PRESCALE     = 100,
  parameter int RAMP_PERIODS = 4,
  parameter int DW           = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  input  logic [DW-1:0] duty_in,
  input  logic          ramp_en,
  output logic          pwm_out,
  output logic [DW-1:0] level,
  output logic          period_start,
  output logic          at_target
);

  localparam logic [3:0]        STEP_LAST = 4'(PWM_STEPS - 1);
  localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_PERIODS - 1);

  logic              tick;
  logic              boundary;
  logic [3:0]        step_q, step_d;
  logic [RAMP_W-1:0] ramp_q, ramp_d;
  level_t            level_q, level_d;
  logic              pwm_q, pwm_d;
  logic              ps_q, ps_d;

  pwm_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .tick    (tick)
  );

  assign boundary = tick && (step_q == STEP_LAST);

  always_comb begin
    step_d  = step_q;
    ramp_d  = ramp_q;
    level_d = level_q;
    pwm_d   = en && (step_q < level_q);
    ps_d    = boundary;
    if (!en) begin
      step_d = '0;
      ramp_d = '0;
    end else begin
      if (tick) step_d = boundary ? 4'd0 : step_q + 4'd1;
      // Holding ramp_cnt at 0 while ramping is off makes every ramp start fresh.
      if (!ramp_en) ramp_d = '0;
      if (boundary) begin
        if (!ramp_en) begin
          level_d = level_t'(duty_in);
        end else if (ramp_q == RAMP_LAST) begin
          level_d = step_toward(level_q, level_t'(duty_in));
          ramp_d  = '0;
        end else begin
          ramp_d  = ramp_q + RAMP_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step_q  <= '0;
      ramp_q  <= '0;
      level_q <= '0;
      pwm_q   <= 1'b0;
      ps_q    <= 1'b0;
    end else begin
      step_q  <= step_d;
      ramp_q  <= ramp_d;
      level_q <= level_d;
      pwm_q   <= pwm_d;
      ps_q    <= ps_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign level        = DW'(level_q);
  assign period_start = ps_q;
  assign at_target    = (DW'(level_q) == duty_in);

endmodule

// File: tb/tb_led_pwm_dimmer.sv
// Bench for led_pwm_dimmer at PRESCALE=2, RAMP_PERIODS=2 (30-clock period).
// Expected high clocks per period are queued as stimulus is applied and compared at each period_start.
module tb_led_pwm_dimmer;

  logic       clk = 1'b0;
  logic       reset_n, en, ramp_en;
  logic [3:0] duty_in;
  logic       pwm_out, period_start, at_target;
  logic [3:0] level;

  int n_chk = 0;
  int n_err = 0;
  int exp_q[$];
  bit mon_armed = 1'b0;
  int mon_hi = 0;

  led_pwm_dimmer #(
    .PRESCALE     (2),
    .RAMP_PERIODS (2),
    .DW           (4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .en           (en),
    .duty_in      (duty_in),
    .ramp_en      (ramp_en),
    .pwm_out      (pwm_out),
    .level        (level),
    .period_start (period_start),
    .at_target    (at_target)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int expv);
    n_chk++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, expv);
    end
  endtask

  // Window of a period: clocks after its period_start up to and including the next one.
  always @(negedge clk) begin
    mon_hi = mon_hi + (pwm_out ? 1 : 0);
    if (period_start) begin
      if (mon_armed && exp_q.size() > 0) check("sb_high_clocks", mon_hi, exp_q.pop_front());
      mon_hi = 0;
    end
  end

  task automatic wait_ps(input string tag, output int cyc, output int hi);
    cyc = 0;
    hi  = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (pwm_out) hi++;
    end while (!period_start && cyc < 200);
    if (!period_start) check({tag, "_timeout"}, int'(period_start), 1);
  endtask

  initial begin
    int cyc, hi, run, psn;
    int ramp_lvl[7] = '{0, 1, 1, 2, 2, 3, 3};

    reset_n = 1'b0; en = 1'b0; duty_in = 4'd0; ramp_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pwm",       int'(pwm_out),      0);
    check("rst_level",     int'(level),        0);
    check("rst_ps",        int'(period_start), 0);
    check("rst_at_target", int'(at_target),    1);
    duty_in = 4'd7;
    #1 check("rst_at_target_d7", int'(at_target), 0);
    duty_in = 4'd0;

    // Duty 0
    @(negedge clk); reset_n = 1'b1; en = 1'b1;
    wait_ps("d0_first", cyc, hi);
    check("d0_first_len", cyc, 30);
    @(negedge clk);
    check("ps_one_cycle", int'(period_start), 0);
    mon_armed = 1'b1;
    repeat (4) exp_q.push_back(0);
    for (int i = 0; i < 4; i++) begin
      wait_ps("d0", cyc, hi);
      check("d0_period_len", cyc, (i == 0) ? 29 : 30);
      check("d0_at_target", int'(at_target), 1);
    end

    // Duty 15
    @(negedge clk); duty_in = 4'd15;
    exp_q.push_back(0);
    repeat (3) exp_q.push_back(30);
    wait_ps("d15_b", cyc, hi);
    check("d15_level", int'(level), 15);
    for (int i = 0; i < 3; i++) begin
      wait_ps("d15", cyc, hi);
      check("d15_low_clocks", cyc - hi, 0);
    end

    // Duty 5, then 9 requested mid-period
    @(negedge clk); duty_in = 4'd5;
    exp_q.push_back(30); exp_q.push_back(10); exp_q.push_back(10); exp_q.push_back(18);
    wait_ps("d5_b", cyc, hi);
    check("d5_level", int'(level), 5);
    wait_ps("d5_c", cyc, hi);
    check("d5_pwm_at_ps", int'(pwm_out), 0);
    @(negedge clk);
    check("d5_pwm_first", int'(pwm_out), 1);
    repeat (13) @(negedge clk);
    duty_in = 4'd9;
    #1 check("d9_level_held", int'(level), 5);
    wait_ps("d9_d", cyc, hi);
    check("d9_level", int'(level), 9);
    wait_ps("d9_e", cyc, hi);

    // Back to 0, then ramp to 3
    @(negedge clk); duty_in = 4'd0;
    exp_q.push_back(18);
    wait_ps("ramp_f", cyc, hi);
    check("ramp_start_level", int'(level), 0);
    @(negedge clk); duty_in = 4'd3; ramp_en = 1'b1;
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(2); exp_q.push_back(2);
    exp_q.push_back(4); exp_q.push_back(4); exp_q.push_back(6);
    for (int i = 0; i < 7; i++) begin
      wait_ps("ramp", cyc, hi);
      check("ramp_level", int'(level), ramp_lvl[i]);
      check("ramp_at_target", int'(at_target), (i >= 5) ? 1 : 0);
    end

    // Enable drop at step 8 with level 6, then re-enable
    @(negedge clk); ramp_en = 1'b0; duty_in = 4'd6;
    exp_q.push_back(6);
    wait_ps("en_n", cyc, hi);
    check("en_level", int'(level), 6);
    @(negedge clk); mon_armed = 1'b0;
    repeat (15) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("dis_pwm_next", int'(pwm_out), 0);
    hi = 0; psn = 0;
    repeat (40) begin
      @(negedge clk);
      if (pwm_out) hi++;
      if (period_start) psn++;
    end
    check("dis_pwm_high", hi, 0);
    check("dis_ps", psn, 0);
    check("dis_level", int'(level), 6);
    en = 1'b1;
    @(negedge clk);
    check("en_pwm_first", int'(pwm_out), 1);
    run = 0;
    while (pwm_out && run < 40) begin
      run++;
      @(negedge clk);
    end
    check("en_high_run", run, 12);
    wait_ps("en_ps", cyc, hi);
    check("en_ps_len", cyc, 17);

    // Asynchronous reset while pwm_out is high
    @(negedge clk);
    check("pre_rst_pwm", int'(pwm_out), 1);
    #1 reset_n = 1'b0;
    #1;
    check("arst_pwm",   int'(pwm_out),      0);
    check("arst_level", int'(level),        0);
    check("arst_ps",    int'(period_start), 0);
    @(negedge clk); reset_n = 1'b1;
    wait_ps("post_rst", cyc, hi);
    check("post_rst_len",   cyc, 30);
    check("post_rst_high",  hi,  0);
    check("post_rst_level", int'(level), 6);

    check("sb_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
